// File: rtl/mat_pkg.sv
// Shared definitions for the matrix-multiply stream adapter and its neighbours.
package mat_pkg;

  localparam int FP_W = 27;

  typedef logic [FP_W-1:0] fp27_t;

  typedef enum logic [1:0] {
    ST_LOAD_A  = 2'd0,
    ST_LOAD_B  = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } adapt_state_t;

  // Bit offset of element (i,j) inside a row-major flat N*N bus.
  function automatic int elem_lsb(input int i, input int j, input int n);
    return FP_W * (i * n + j);
  endfunction

endpackage

// File: rtl/matmul_stream_adapter.sv
// Streaming front/back end for the combinational N x N matrix multiplier.
// Elements arrive one per handshake (row-major A, then row-major B), are held
// on the flat operand buses, and after LAT settle cycles the flat result is
// captured and streamed back out row-major. Elements pass through bit-exact.
//
// state      | meaning
// -----------+------------------------------------------------------------
// LOAD_A     | accept A elements into mat_a[idx]
// LOAD_B     | accept B elements into mat_b[idx]
// COMPUTE    | wait LAT cycles for the multiplier, capture mat_out on last
// DRAIN      | present result[idx] on the output stream until out_last taken
module matmul_stream_adapter #(
  parameter int N    = 4,
  parameter int FP_W = mat_pkg::FP_W,
  parameter int LAT  = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FP_W-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FP_W-1:0]       out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [FP_W*N*N-1:0]   mat_a,
  output logic [FP_W*N*N-1:0]   mat_b,
  input  logic [FP_W*N*N-1:0]   mat_out
);
  import mat_pkg::*;

  localparam int NE     = N * N;
  localparam int IDX_W  = (NE > 1) ? $clog2(NE) : 1;
  localparam int SET_W  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int FLAT_W = FP_W * NE;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NE - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(LAT - 1);

  adapt_state_t       state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [SET_W-1:0]   settle, settle_nxt;
  logic               wr_a, wr_b, cap;
  logic [FLAT_W-1:0]  res_buf;
  int                 elem_base;

  assign elem_base = FP_W * int'(idx);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_LOAD_A;
    else         state <= state_nxt;
  end

  // Next-state, counter updates, write strobes and stream handshake outputs.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    settle_nxt = settle;
    wr_a       = 1'b0;
    wr_b       = 1'b0;
    cap        = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    case (state)
      ST_LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_a = 1'b1;
          if (idx == IDX_LAST) begin
            idx_nxt   = '0;
            state_nxt = ST_LOAD_B;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      ST_LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_b = 1'b1;
          if (idx == IDX_LAST) begin
            idx_nxt   = '0;
            state_nxt = ST_COMPUTE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        if (settle == SET_LAST) begin
          settle_nxt = '0;
          cap        = 1'b1;
          idx_nxt    = '0;
          state_nxt  = ST_DRAIN;
        end else begin
          settle_nxt = settle + 1'b1;
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (idx == IDX_LAST);
        if (out_ready) begin
          if (idx == IDX_LAST) begin
            idx_nxt   = '0;
            state_nxt = ST_LOAD_A;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = ST_LOAD_A;
    endcase
  end

  // Element index and settle counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx    <= '0;
      settle <= '0;
    end else begin
      idx    <= idx_nxt;
      settle <= settle_nxt;
    end
  end

  // Operand registers: written in place, never cleared except by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mat_a <= '0;
      mat_b <= '0;
    end else begin
      if (wr_a) mat_a[elem_base +: FP_W] <= in_data;
      if (wr_b) mat_b[elem_base +: FP_W] <= in_data;
    end
  end

  // Result buffer: snapshot of the settled multiplier output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  res_buf <= '0;
    else if (cap) res_buf <= mat_out;
  end

  // Output data is zero outside DRAIN so idle buses stay quiet.
  assign out_data = out_valid ? res_buf[elem_base +: FP_W] : '0;
  assign busy     = !((state == ST_LOAD_A) && (idx == '0));

endmodule

// File: tb/tb_matmul_stream_adapter.sv
// Directed bench for matmul_stream_adapter with N=2, one instance at LAT=1
// and one at LAT=3, each beside a small integer-valued multiplier stub.
module tb_matmul_stream_adapter;
  import mat_pkg::*;

  localparam int W  = 27;
  localparam int FW = W * 4;

  localparam logic [W-1:0] F0 = 27'h0000000;
  localparam logic [W-1:0] F1 = 27'h1FC0000;
  localparam logic [W-1:0] F2 = 27'h2000000;
  localparam logic [W-1:0] F3 = 27'h2020000;
  localparam logic [W-1:0] F4 = 27'h2040000;
  localparam logic [W-1:0] FJ = 27'h7FFFFFF;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic sel = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic out_ready = 1'b0;

  logic in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
  logic [W-1:0] out_data1;
  logic [FW-1:0] mat_a1, mat_b1, mat_out1;
  logic in_valid3, in_ready3, out_valid3, out_ready3, out_last3, busy3;
  logic [W-1:0] out_data3;
  logic [FW-1:0] mat_a3, mat_b3, mat_out3, mo3_s1, mo3_s2;

  logic o_in_ready, o_out_valid, o_out_last, o_busy;
  logic [W-1:0] o_out_data;
  logic [FW-1:0] o_mat_a, o_mat_b;

  int cyc = 0;
  int last_hs = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int fp2int(input fp27_t f);
    int e;
    e = int'(f[25:18]);
    if (e < 127 || e > 145) return 0;
    return int'({13'b0, 1'b1, f[17:0]} >> (145 - e));
  endfunction

  function automatic fp27_t int2fp(input int v);
    int p;
    logic [31:0] m;
    logic [7:0] e;
    if (v <= 0) return '0;
    p = 0;
    for (int i = 0; i < 19; i++) if (v[i]) p = i;
    m = 32'(v) << (18 - p);
    e = 8'(127 + p);
    return {1'b0, e, m[17:0]};
  endfunction

  function automatic logic [FW-1:0] mm(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic [FW-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++)
          s += fp2int(a[elem_lsb(i, k, 2) +: W]) * fp2int(b[elem_lsb(k, j, 2) +: W]);
        r[elem_lsb(i, j, 2) +: W] = int2fp(s);
      end
    return r;
  endfunction

  assign mat_out1 = mm(mat_a1, mat_b1);

  always @(posedge clk) begin
    mo3_s1 <= mm(mat_a3, mat_b3);
    mo3_s2 <= mo3_s1;
  end
  assign mat_out3 = mo3_s2;

  assign in_valid1  = sel ? 1'b0 : in_valid;
  assign in_valid3  = sel ? in_valid : 1'b0;
  assign out_ready1 = sel ? 1'b0 : out_ready;
  assign out_ready3 = sel ? out_ready : 1'b0;
  assign o_in_ready  = sel ? in_ready3  : in_ready1;
  assign o_out_valid = sel ? out_valid3 : out_valid1;
  assign o_out_last  = sel ? out_last3  : out_last1;
  assign o_out_data  = sel ? out_data3  : out_data1;
  assign o_busy      = sel ? busy3      : busy1;
  assign o_mat_a     = sel ? mat_a3     : mat_a1;
  assign o_mat_b     = sel ? mat_b3     : mat_b1;

  matmul_stream_adapter #(.N(2), .LAT(1)) u_dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_last(out_last1), .busy(busy1),
    .mat_a(mat_a1), .mat_b(mat_b1), .mat_out(mat_out1)
  );

  matmul_stream_adapter #(.N(2), .LAT(3)) u_dut_lat3 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_last(out_last3), .busy(busy3),
    .mat_a(mat_a3), .mat_b(mat_b3), .mat_out(mat_out3)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Entered and left at a negedge; keeps in_valid high until accepted.
  task automatic send(input logic [W-1:0] d);
    int g;
    in_valid = 1'b1;
    in_data  = d;
    g = 0;
    while (!o_in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("send_timeout", 128'(g), 128'(0));
    last_hs = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] a[4], input logic [W-1:0] b[4], input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send(a[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send(b[i]);
    end
  endtask

  task automatic wait_out(input int lat_exp);
    int g;
    g = 0;
    while (!o_out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("first_valid_lat", 128'(cyc - last_hs), 128'(lat_exp));
  endtask

  // out_ready follows pat[k%4] per cycle; stalled elements must hold.
  task automatic drain(input logic [W-1:0] e[4], input logic [3:0] pat);
    int n, k;
    logic r;
    n = 0;
    k = 0;
    while (n < 4 && k < 40) begin
      r = pat[k % 4];
      out_ready = r;
      chk("drain_valid", 128'(o_out_valid), 128'(1));
      chk("drain_data", 128'(o_out_data), 128'(e[n]));
      chk("drain_last", 128'(o_out_last), 128'(n == 3));
      if (r && o_out_valid) n++;
      k++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain_count", 128'(n), 128'(4));
    chk("after_drain_valid", 128'(o_out_valid), 128'(0));
    chk("after_drain_in_ready", 128'(o_in_ready), 128'(1));
  endtask

  logic [W-1:0] a_v[4], b_v[4], e_v[4];

  initial begin
    // Reset values.
    #1;
    chk("rst_in_ready", 128'(o_in_ready), 128'(1));
    chk("rst_out_valid", 128'(o_out_valid), 128'(0));
    chk("rst_out_last", 128'(o_out_last), 128'(0));
    chk("rst_out_data", 128'(o_out_data), 128'(0));
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_mat_a", 128'(o_mat_a), 128'(0));
    chk("rst_mat_b", 128'(o_mat_b), 128'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(o_in_ready), 128'(1));

    // Input bubbles and output backpressure: A=[1,2;3,1], B=I -> A.
    a_v = '{F1, F2, F3, F1};
    b_v = '{F1, F0, F0, F1};
    load(a_v, b_v, 1'b1);
    chk("pack_a_elem10", 128'(o_mat_a[54 +: W]), 128'(F3));
    chk("pack_a_flat", 128'(o_mat_a), 128'({F1, F3, F2, F1}));
    chk("pack_b_flat", 128'(o_mat_b), 128'({F1, F0, F0, F1}));
    wait_out(2);
    e_v = '{F1, F2, F3, F1};
    drain(e_v, 4'b1001);

    // in_valid held high through COMPUTE/DRAIN: A=2I, B=[1,2;2,1] -> [2,4;4,2].
    a_v = '{F2, F0, F0, F2};
    b_v = '{F1, F2, F2, F1};
    load(a_v, b_v, 1'b0);
    in_valid = 1'b1;
    in_data  = FJ;
    chk("compute_in_ready", 128'(o_in_ready), 128'(0));
    chk("compute_busy", 128'(o_busy), 128'(1));
    wait_out(2);
    e_v = '{F2, F4, F4, F2};
    drain(e_v, 4'b1111);
    chk("hold_mat_a", 128'(o_mat_a), 128'({F2, F0, F0, F2}));
    chk("hold_mat_b", 128'(o_mat_b), 128'({F1, F2, F2, F1}));
    chk("idle_busy", 128'(o_busy), 128'(0));
    @(negedge clk);
    in_valid = 1'b0;
    chk("reload_a00", 128'(o_mat_a[0 +: W]), 128'(FJ));
    chk("reload_a01_kept", 128'(o_mat_a[27 +: W]), 128'(F0));
    chk("reload_busy", 128'(o_busy), 128'(1));

    // Reset in the middle of LOAD_B.
    send(F1); send(F1); send(F1);
    send(F2); send(F2);
    chk("midb_in_ready", 128'(o_in_ready), 128'(1));
    chk("midb_busy", 128'(o_busy), 128'(1));
    resetn = 1'b0;
    #1;
    chk("midb_rst_in_ready", 128'(o_in_ready), 128'(1));
    chk("midb_rst_out_valid", 128'(o_out_valid), 128'(0));
    chk("midb_rst_busy", 128'(o_busy), 128'(0));
    chk("midb_rst_mat_a", 128'(o_mat_a), 128'(0));
    chk("midb_rst_mat_b", 128'(o_mat_b), 128'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Fresh identity load after reset: A=I, B=[1,2;2,1].
    a_v = '{F1, F0, F0, F1};
    b_v = '{F1, F2, F2, F1};
    load(a_v, b_v, 1'b0);
    wait_out(2);
    e_v = '{F1, F2, F2, F1};
    drain(e_v, 4'b1111);

    // LAT=3 instance: A=[1,1;0,1], B=[1,2;2,1] -> [3,3;2,1].
    sel = 1'b1;
    #1;
    chk("lat3_idle_busy", 128'(o_busy), 128'(0));
    @(negedge clk);
    a_v = '{F1, F1, F0, F1};
    b_v = '{F1, F2, F2, F1};
    load(a_v, b_v, 1'b0);
    wait_out(4);
    e_v = '{F3, F3, F2, F1};
    drain(e_v, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
